// File: rtl/mem_port_if.sv
// Bundle of the fetch requester, data requester and shared-memory signals
// around the single-port memory arbiter.
interface mem_port_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready;
  logic [DW-1:0] m_rdata;
  logic          stall_if;
  logic          stall_mem;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, m_ready, m_rdata,
    output if_done, if_rdata, dm_done, dm_rdata, m_req, m_we, m_addr, m_wdata,
           stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, m_ready, m_rdata,
    input  if_done, if_rdata, dm_done, dm_rdata, m_req, m_we, m_addr, m_wdata,
           stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data-stage requests onto one single-port
// memory, one transaction at a time, with a bounded fetch-starvation window.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  mem_port_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

  localparam logic [3:0] LIMIT4 = 4'(STARVE_LIMIT);

  state_t        state_r, state_s;
  logic [3:0]    starve_r, starve_s;
  logic          grant_if_s, grant_dm_s;
  logic          m_req_r, m_we_r;
  logic [AW-1:0] m_addr_r;
  logic [DW-1:0] m_wdata_r;
  logic [DW-1:0] if_rdata_r, dm_rdata_r;
  logic          if_done_r, dm_done_r;

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      starve_r <= 4'd0;
    end else begin
      state_r  <= state_s;
      starve_r <= starve_s;
    end
  end

  // Grant decision and next-state logic; the counter cannot exceed the limit
  // because a DM grant with a pending fetch needs starve_r below it.
  always_comb begin
    state_s    = state_r;
    starve_s   = starve_r;
    grant_if_s = 1'b0;
    grant_dm_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.dm_req && (!bus.if_req || (starve_r < LIMIT4))) begin
          grant_dm_s = 1'b1;
          state_s    = BUSY_DM;
          if (bus.if_req) begin
            starve_s = starve_r + 4'd1;
          end else begin
            starve_s = 4'd0;
          end
        end else if (bus.if_req) begin
          grant_if_s = 1'b1;
          state_s    = BUSY_IF;
          starve_s   = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (bus.m_ready) begin
          state_s = RESP;
        end else begin
          state_s = state_r;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Memory-side command registers, read-data capture and done pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_req_r    <= 1'b0;
      m_we_r     <= 1'b0;
      m_addr_r   <= '0;
      m_wdata_r  <= '0;
      if_rdata_r <= '0;
      dm_rdata_r <= '0;
      if_done_r  <= 1'b0;
      dm_done_r  <= 1'b0;
    end else begin
      if_done_r <= 1'b0;
      dm_done_r <= 1'b0;
      if (grant_dm_s) begin
        m_req_r   <= 1'b1;
        m_we_r    <= bus.dm_we;
        m_addr_r  <= bus.dm_addr;
        m_wdata_r <= bus.dm_wdata;
      end else if (grant_if_s) begin
        m_req_r  <= 1'b1;
        m_we_r   <= 1'b0;
        m_addr_r <= bus.if_addr;
      end else if (((state_r == BUSY_IF) || (state_r == BUSY_DM)) && bus.m_ready) begin
        m_req_r <= 1'b0;
        m_we_r  <= 1'b0;
        if (state_r == BUSY_IF) begin
          if_rdata_r <= bus.m_rdata;
          if_done_r  <= 1'b1;
        end else begin
          dm_done_r <= 1'b1;
          // A completed write leaves the data-stage read register untouched.
          if (!m_we_r) begin
            dm_rdata_r <= bus.m_rdata;
          end
        end
      end
    end
  end

  assign bus.m_req     = m_req_r;
  assign bus.m_we      = m_we_r;
  assign bus.m_addr    = m_addr_r;
  assign bus.m_wdata   = m_wdata_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.dm_rdata  = dm_rdata_r;
  assign bus.if_done   = if_done_r;
  assign bus.dm_done   = dm_done_r;
  assign bus.stall_if  = bus.if_req & ~if_done_r;
  assign bus.stall_mem = bus.dm_req & ~dm_done_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: requesters, memory and a transaction-timing reference
// model for mem_port_arbiter.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;
  mem_port_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp, input int cyc);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [3:0] w;
    w = 4'($urandom_range(0, 15));
    return {26'd0, w, 2'b00};
  endfunction

  // Reference model state: one transaction described by its grant and done cycle.
  logic [DW-1:0] mem [16];
  bit            if_pend, dm_pend, dm_w;
  logic [AW-1:0] if_a, dm_a;
  logic [DW-1:0] dm_d;
  bit            active, owner_dm, g_wr, in_rst, real_rdy, e_mreq, e_ifd, e_dmd;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wd, exp_if_rd, exp_dm_rd;
  int            starve, t_grant, t_done, lat, p_if, p_dm, n_resets;

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.m_ready = 1'b0; bus.m_rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    if_pend = 0; dm_pend = 0; active = 0; starve = 0; n_resets = 0;
    exp_if_rd = '0; exp_dm_rd = '0; t_grant = 0; t_done = 0;
    g_addr = '0; g_wd = '0; g_wr = 0; owner_dm = 0; dm_w = 0;
    if_a = '0; dm_a = '0; dm_d = '0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      // Middle window: both requesters always busy, exercising starvation.
      if (c >= 1500 && c < 2000) begin p_if = 100; p_dm = 100; end
      else begin p_if = 30; p_dm = 40; end

      if (!if_pend && $urandom_range(0, 99) < p_if) begin
        if_pend = 1; if_a = rand_addr();
      end
      if (!dm_pend && $urandom_range(0, 99) < p_dm) begin
        dm_pend = 1; dm_a = rand_addr(); dm_w = 1'($urandom_range(0, 1)); dm_d = $urandom;
      end
      bus.if_req  = if_pend;
      bus.if_addr = if_pend ? if_a : $urandom;
      bus.dm_req  = dm_pend;
      bus.dm_we   = dm_pend ? dm_w : 1'($urandom_range(0, 1));
      bus.dm_addr = dm_pend ? dm_a : $urandom;
      bus.dm_wdata = dm_pend ? dm_d : $urandom;
      // The granted requester's inputs must be ignored while busy.
      if (active && c > t_grant && !owner_dm) bus.if_addr = $urandom;
      if (active && c > t_grant && owner_dm) begin
        bus.dm_addr = $urandom; bus.dm_wdata = $urandom; bus.dm_we = 1'($urandom_range(0, 1));
      end

      in_rst = (c < 3) || (active && c > t_grant && c < t_done - 1 &&
                           n_resets < 20 && $urandom_range(0, 99) < 5);
      rst = in_rst ? 1'b0 : 1'b1;
      if (in_rst) begin
        if (c >= 3) n_resets++;
        active = 0; starve = 0; exp_if_rd = '0; exp_dm_rd = '0;
      end

      if (!in_rst && !active && (if_pend || dm_pend)) begin
        if (dm_pend && (!if_pend || starve < LIMIT)) begin
          owner_dm = 1; g_addr = dm_a; g_wr = dm_w; g_wd = dm_d;
          starve = if_pend ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
        end else begin
          owner_dm = 0; g_addr = if_a; g_wr = 0;
          starve = 0;
        end
        lat = ($urandom_range(0, 3) == 0) ? 5 : $urandom_range(1, 3);
        t_grant = c; t_done = c + 1 + lat; active = 1;
      end

      real_rdy = active && (c == t_done - 1);
      bus.m_ready = 1'b0;
      bus.m_rdata = $urandom;
      if (real_rdy) begin
        bus.m_ready = 1'b1;
        if (!g_wr) bus.m_rdata = mem[g_addr[5:2]];
      end else if ((!active || c == t_grant || c == t_done) && $urandom_range(0, 99) < 15) begin
        bus.m_ready = 1'b1;
      end

      #1;
      e_mreq = active && c > t_grant && c < t_done;
      e_ifd  = active && c == t_done && !owner_dm;
      e_dmd  = active && c == t_done && owner_dm;
      check_eq("m_req", 32'(bus.m_req), 32'(e_mreq), c);
      check_eq("m_we", 32'(bus.m_we), 32'(e_mreq && g_wr), c);
      if (e_mreq) check_eq("m_addr", bus.m_addr, g_addr, c);
      if (e_mreq && g_wr) check_eq("m_wdata", bus.m_wdata, g_wd, c);
      if (in_rst) begin
        check_eq("rst_m_addr", bus.m_addr, 32'd0, c);
        check_eq("rst_m_wdata", bus.m_wdata, 32'd0, c);
      end
      check_eq("if_done", 32'(bus.if_done), 32'(e_ifd), c);
      check_eq("dm_done", 32'(bus.dm_done), 32'(e_dmd), c);
      check_eq("if_rdata", bus.if_rdata, exp_if_rd, c);
      check_eq("dm_rdata", bus.dm_rdata, exp_dm_rd, c);
      check_eq("stall_if", 32'(bus.stall_if), 32'(if_pend && !e_ifd), c);
      check_eq("stall_mem", 32'(bus.stall_mem), 32'(dm_pend && !e_dmd), c);

      if (real_rdy) begin
        if (!owner_dm) exp_if_rd = bus.m_rdata;
        else if (!g_wr) exp_dm_rd = bus.m_rdata;
        else mem[g_addr[5:2]] = g_wd;
      end
      if (active && c == t_done) begin
        if (owner_dm) dm_pend = 0;
        else if_pend = 0;
        active = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
